counter_monitor: RTL

COUNTER_MONITOR -- requirements
Module: counter_monitor

---
 rtl/counter_monitor_if.sv | 26 ++
 rtl/counter_monitor.sv | 79 +++++++
 2 files changed

// File: rtl/counter_monitor_if.sv
// counter_monitor_if: stimulus/result bundle between an up/down counter source and its monitor.
`default_nettype none

interface counter_monitor_if;
  logic       upDown;
  logic [3:0] counter;
  logic       clr_err;
  logic       wrap;
  logic [7:0] wrap_count;
  logic       dir_chg;
  logic       step_err;
  logic [7:0] err_count;
  logic [1:0] state;

  modport master (
    output upDown, counter, clr_err,
    input  wrap, wrap_count, dir_chg, step_err, err_count, state
  );

  modport slave (
    input  upDown, counter, clr_err,
    output wrap, wrap_count, dir_chg, step_err, err_count, state
  );
endinterface

`default_nettype wire

// File: rtl/counter_monitor.sv
// +--------------------------------------------------------------------+
// | counter_monitor: checks a 4-bit up/down counter for legal steps,   |
// | counts wraps and illegal steps, flags direction changes.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module counter_monitor (
  input  wire logic          clk,
  input  wire logic          rst,
  counter_monitor_if.slave   bus
);

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } state_t;

  state_t     st;
  logic [3:0] prev_cnt;
  logic       prev_dir;
  logic [3:0] expected;
  logic       step_ok;
  logic       wrap_step;

  // The counter reflects the direction sampled one edge earlier, hence prev_dir.
  assign expected  = prev_dir ? (prev_cnt + 4'd1) : (prev_cnt - 4'd1);
  assign step_ok   = (bus.counter == expected);
  assign wrap_step = (prev_dir && (prev_cnt == 4'd15)) || (!prev_dir && (prev_cnt == 4'd0));

  assign bus.state    = st;
  assign bus.step_err = (st == FAULT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      st             <= INIT;
      prev_cnt       <= 4'd0;
      prev_dir       <= 1'b0;
      bus.wrap       <= 1'b0;
      bus.wrap_count <= 8'd0;
      bus.dir_chg    <= 1'b0;
      bus.err_count  <= 8'd0;
    end else begin
      prev_cnt    <= bus.counter;
      prev_dir    <= bus.upDown;
      bus.wrap    <= 1'b0;
      bus.dir_chg <= (st != INIT) && (bus.upDown != prev_dir);

      if (bus.clr_err) begin
        bus.err_count <= 8'd0;
        st            <= INIT;
      end else begin
        case (st)
          INIT: st <= TRACK;
          TRACK: begin
            if (step_ok) begin
              if (wrap_step) begin
                bus.wrap <= 1'b1;
                if (bus.wrap_count != 8'hFF)
                  bus.wrap_count <= bus.wrap_count + 8'd1;
              end
            end else if (bus.counter != 4'd0) begin
              // A jump to zero is an upstream reset and is silently resynced.
              st <= FAULT;
              if (bus.err_count != 8'hFF)
                bus.err_count <= bus.err_count + 8'd1;
            end
          end
          FAULT:   st <= FAULT;
          default: st <= INIT;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
